adder_arbiter: RTL and testbench

//  Shares one Nbit_Adder instance between two requesters (req0, req1).
//  - Round-robin grant; operands and results are registered.
//  - One response channel carries the result plus the id of the requester it belongs to.
//  - Sits between operand producers (e.g. ALU/accumulator FSMs) and the single adder datapath.

---
 rtl/adder_arbiter_pkg.sv | 27 ++
 rtl/adder_arbiter_nbit_adder.sv | 15 +
 rtl/adder_arbiter.sv | 126 ++++++++++++
 tb/tb_adder_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: FSM encoding,
// requester ids and the round-robin pick helper.
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    // A lone valid requester always wins; when both are valid, rr_ptr decides.
    function automatic logic rr_pick(input logic valid0, input logic valid1, input logic ptr);
        logic id;
        if (valid0 && valid1) begin
            id = ptr;
        end else if (valid1) begin
            id = ID_REQ1;
        end else begin
            id = ID_REQ0;
        end
        return id;
    endfunction

endpackage

// File: rtl/adder_arbiter_nbit_adder.sv
// Plain n-bit ripple-style adder with carry in/out; purely combinational.
module Nbit_Adder #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    // Full (n+1)-bit sum; the top bit is the carry-out.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};

endmodule

// File: rtl/adder_arbiter.sv
// Shares one Nbit_Adder between two requesters with round-robin arbitration.
// Each accepted operation takes IDLE -> EXEC -> RESP; no new request is
// accepted until the pending result has been handed to the consumer.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | waiting for a request; combinational grant drives req*_ready
//  ST_EXEC | adder evaluates latched operands; result captured at the edge
//  ST_RESP | result presented on rsp_*; held until rsp_ready
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout
);

    state_t       state;
    state_t       state_next;
    logic         rr_ptr;
    logic         grant_id;
    logic         accept;

    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         op_cin;
    logic         op_id;

    logic [N-1:0] add_sum;
    logic         add_cout;

    Nbit_Adder #(.n(N)) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, ready and next-state decode. Ready is gated by rst_n so both
    // ready outputs read 0 while reset is held, even with valid asserted.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        grant_id   = rr_pick(req0_valid, req1_valid, rr_ptr);
        unique case (state)
            ST_IDLE: begin
                if ((req0_valid || req1_valid) && rst_n) begin
                    accept     = 1'b1;
                    req0_ready = (grant_id == ID_REQ0);
                    req1_ready = (grant_id == ID_REQ1);
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept, result capture in EXEC, round-robin update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            op_id    <= ID_REQ0;
            rr_ptr   <= ID_REQ0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= ID_REQ0;
        end else begin
            if (accept) begin
                op_a   <= (grant_id == ID_REQ1) ? req1_a   : req0_a;
                op_b   <= (grant_id == ID_REQ1) ? req1_b   : req0_b;
                op_cin <= (grant_id == ID_REQ1) ? req1_cin : req0_cin;
                op_id  <= grant_id;
                rr_ptr <= ~grant_id;
            end
            if (state == ST_EXEC) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
                rsp_id   <= op_id;
            end
        end
    end

    // RESP is entered only from the EXEC capture edge, so valid follows state.
    assign rsp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and random checks for adder_arbiter: reset, single ops, wrap,
// contention, backpressure, mid-operation reset and a scoreboarded random run.
module tb_adder_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [N-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [N-1:0] rsp_sum;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         cout;
    } vec_t;

    typedef struct {
        logic         id;
        logic [N:0]   full;
    } exp_t;

    vec_t vecs[8];
    exp_t exp_q[$];
    int   rand_ops  = 0;
    int   rand_rsps = 0;

    adder_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic cin);
        req0_valid = (id == 1'b0);
        req1_valid = (id == 1'b1);
        if (id) begin
            req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_a = a; req0_b = b; req0_cin = cin;
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        set_req(v.id, v.a, v.b, v.cin);
        #1;
        chk("vec_ready_granted", v.id ? req1_ready : req0_ready, 1);
        chk("vec_ready_other", v.id ? req0_ready : req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'hEE; req0_b = 8'hDD; req1_a = 8'hCC; req1_b = 8'hBB;
        #1;
        chk("vec_exec_ready", {req0_ready, req1_ready}, 0);
        chk("vec_exec_valid", rsp_valid, 0);
        @(negedge clk); #1;
        chk("vec_rsp_valid", rsp_valid, 1);
        chk("vec_rsp_data", {rsp_id, rsp_cout, rsp_sum}, {v.id, v.cout, v.sum});
        @(negedge clk); #1;
        chk("vec_after_valid", rsp_valid, 0);
        chk("vec_after_hold", {rsp_id, rsp_cout, rsp_sum}, {v.id, v.cout, v.sum});
    endtask

    task automatic rand_cycle(input bit allow_new);
        exp_t e;
        @(negedge clk);
        if (allow_new) begin
            if (!req0_valid || $urandom_range(0, 3) == 0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cin = 1'($urandom_range(0, 1));
            end
            if (!req1_valid || $urandom_range(0, 3) == 0) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cin = 1'($urandom_range(0, 1));
            end
            rsp_ready = 1'($urandom_range(0, 1));
        end else begin
            req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        end
        #1;
        if (req0_ready && req1_ready) chk("rand_both_ready", 1, 0);
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rand_rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rand_rsp", {rsp_id, rsp_cout, rsp_sum}, {e.id, e.full});
            end
            rand_rsps++;
        end
        if (req0_valid && req0_ready) begin
            e.id = 1'b0;
            e.full = {1'b0, req0_a} + {1'b0, req0_b} + {8'd0, req0_cin};
            exp_q.push_back(e);
            rand_ops++;
        end
        if (req1_valid && req1_ready) begin
            e.id = 1'b1;
            e.full = {1'b0, req1_a} + {1'b0, req1_b} + {8'd0, req1_cin};
            exp_q.push_back(e);
            rand_ops++;
        end
    endtask

    initial begin
        int budget;
        int seen;

        vecs[0] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
        vecs[2] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{1'b1, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[4] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{1'b1, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

        // Reset with no clock edge yet; valid high must not leak into ready.
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_cin = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("reset_ready", {req0_ready, req1_ready}, 0);
        chk("reset_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held while req1 waits and is never accepted.
        @(negedge clk);
        set_req(1'b0, 8'h3C, 8'h04, 1'b1);
        rsp_ready = 1'b0;
        #1;
        chk("bp_accept", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02; req1_cin = 1'b0;
        #1;
        chk("bp_exec_ready", {req0_ready, req1_ready}, 0);
        @(negedge clk); #1;
        chk("bp_rsp_first", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, {1'b1, 1'b0, 1'b0, 8'h41});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("bp_rsp_hold", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, {1'b1, 1'b0, 1'b0, 8'h41});
            chk("bp_ready_low", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_released", rsp_valid, 0);
        chk("bp_idle_grant", req1_ready, 1);
        chk("bp_data_kept", {rsp_id, rsp_cout, rsp_sum}, {1'b0, 1'b0, 8'h41});
        req1_valid = 1'b0;
        #1;
        chk("bp_drop_ready", req1_ready, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("bp_drop_no_rsp", seen, 0);

        // Reset during EXEC: op from req0 leaves rr_ptr=1, reset must clear it.
        @(negedge clk);
        set_req(1'b0, 8'h01, 8'h01, 1'b0);
        #1;
        chk("mid_accept", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out", {rsp_valid, rsp_id, rsp_cout, rsp_sum, req0_ready, req1_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", seen, 0);

        // Contention straight after reset: grants alternate 0,1,0,1.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h20; req1_cin = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            budget = 0;
            while (!(req0_ready || req1_ready) && budget < 10) begin
                @(negedge clk); #1;
                budget++;
            end
            chk("cont_grant_timeout", (budget < 10), 1);
            chk("cont_both_ready", (req0_ready && req1_ready), 0);
            chk("cont_grant_id", req1_ready, k % 2);
            @(negedge clk); #1;
            chk("cont_exec_ready", {req0_ready, req1_ready}, 0);
            @(negedge clk); #1;
            chk("cont_rsp_valid", rsp_valid, 1);
            if (k % 2 == 0) chk("cont_rsp0", {rsp_id, rsp_cout, rsp_sum}, {1'b0, 1'b0, 8'h30});
            else            chk("cont_rsp1", {rsp_id, rsp_cout, rsp_sum}, {1'b1, 1'b1, 8'h11});
            @(negedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Random traffic against the scoreboard.
        budget = 0;
        while (rand_ops < 1000 && budget < 20000) begin
            rand_cycle(1'b1);
            budget++;
        end
        chk("rand_ops_done", (rand_ops >= 1000), 1);
        for (int d = 0; d < 10; d++) rand_cycle(1'b0);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_rsp_count", rand_rsps, rand_ops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
